// File: rtl/spi_ram_ctrl.sv
// Purpose : single-port RAM controller behind the SPI slave; decodes din[9:8] as
//           WR_ADDR / WR_DATA / RD_ADDR / RD_DATA and returns read data on dout/tx_valid.
// Latency : dout/tx_valid update on the same edge that accepts the RD_DATA command.
// Backpressure: none; one command per rising edge of rx_valid, held level is ignored.
//
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   din      - command word: [9:8] command, [7:0] payload
//   rx_valid - level flag from the SPI slave, high while din is complete
//   dout     - read data handed back to the slave for MISO
//   tx_valid - dout valid; held until the next accepted command
//   cmd_err  - sticky protocol-error flag (data command before its address)
//
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment the write/read
// address after each executed WR_DATA/RD_DATA (wrapping at MEM_DEPTH-1).
// MEM_DEPTH must equal 2**ADDR_SIZE so the address registers wrap naturally.

module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       cmd_err
);

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  logic                 r_rx_valid_d;
  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_wr_addr_set;
  logic                 r_rd_addr_set;
  logic [7:0]           r_dout;
  logic                 r_tx_valid;
  logic                 r_cmd_err;
  logic [7:0]           r_mem [MEM_DEPTH];

  logic       w_accept;
  logic [1:0] w_cmd;
  logic       w_wr_exec;
  logic       w_rd_exec;
  logic       w_data_err;

  // Rising edge of the rx_valid level: a held level yields exactly one accept.
  assign w_accept   = rx_valid & ~r_rx_valid_d;
  assign w_cmd      = din[9:8];
  assign w_wr_exec  = w_accept && (w_cmd == CMD_WR_DATA) && r_wr_addr_set;
  assign w_rd_exec  = w_accept && (w_cmd == CMD_RD_DATA) && r_rd_addr_set;
  // Data command issued before its address has ever been loaded.
  assign w_data_err = w_accept &&
                      (((w_cmd == CMD_WR_DATA) && !r_wr_addr_set) ||
                       ((w_cmd == CMD_RD_DATA) && !r_rd_addr_set));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_valid_d  <= 1'b0;
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_wr_addr_set <= 1'b0;
      r_rd_addr_set <= 1'b0;
      r_dout        <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_rx_valid_d <= rx_valid;

      // Any accepted command retires the previous read result; a new
      // executed RD_DATA re-asserts it on the same edge.
      if (w_accept) begin
        r_tx_valid <= w_rd_exec;
      end

      if (w_data_err) begin
        r_cmd_err <= 1'b1;
      end

      if (w_accept && (w_cmd == CMD_WR_ADDR)) begin
        r_wr_addr     <= din[ADDR_SIZE-1:0];
        r_wr_addr_set <= 1'b1;
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (w_wr_exec) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
`endif

      if (w_accept && (w_cmd == CMD_RD_ADDR)) begin
        r_rd_addr     <= din[ADDR_SIZE-1:0];
        r_rd_addr_set <= 1'b1;
      end
`ifdef SPI_RAM_AUTOINC_EN
      else if (w_rd_exec) begin
        r_rd_addr <= r_rd_addr + 1'b1;
      end
`endif

      if (w_rd_exec) begin
        r_dout <= r_mem[r_rd_addr];
      end
    end
  end

  // Memory array carries no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_exec) begin
      r_mem[r_wr_addr] <= din[7:0];
    end
  end

  assign dout     = r_dout;
  assign tx_valid = r_tx_valid;
  assign cmd_err  = r_cmd_err;

endmodule
